// File: rtl/shiftadd_mul_pkg.sv
// Shared types and constants for the shift-add multiplier scheduler.
// Optional feature macro: MUL_WDOG_EN (RUN-state watchdog, see top module).
package shiftadd_mul_pkg;

    // Scheduler sequencing states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int W_DEFAULT     = 8;
    localparam int N_REQ_DEFAULT = 4;

    // Engine needs W run cycles; the watchdog allows a small margin on top
    localparam int WDOG_LIMIT = W_DEFAULT + 4;

    // Requester index width; never below one bit
    function automatic int idw_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Watchdog limit for an arbitrary operand width
    function automatic int wdog_limit_of(input int w);
        return w + 4;
    endfunction

endpackage

// File: rtl/shiftadd_mul_scheduler_rr_arbiter.sv
// Round-robin arbiter: picks the first asserted request at or after the
// pointer (wrapping) and returns it both as a one-hot grant and an index.
module rr_arbiter
    import shiftadd_mul_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEFAULT,
    parameter int IDW   = idw_of(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDW-1:0]   ptr,
    output logic [N_REQ-1:0] grant,
    output logic [IDW-1:0]   grant_idx,
    output logic             grant_found
);

    // Candidate k is requester (ptr + k) mod N_REQ
    logic [IDW:0]   cand_sum [N_REQ];
    logic [IDW-1:0] cand_idx [N_REQ];
    logic [N_REQ-1:0] cand_req;

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_cand
            assign cand_sum[gi] = {1'b0, ptr} + (IDW+1)'(gi);
            assign cand_idx[gi] = (cand_sum[gi] >= (IDW+1)'(N_REQ))
                                ? IDW'(cand_sum[gi] - (IDW+1)'(N_REQ))
                                : cand_sum[gi][IDW-1:0];
            assign cand_req[gi] = req[cand_idx[gi]];
        end
    endgenerate

    // Lowest rotated offset wins: scan downwards so the last hit is the winner
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (cand_req[k]) begin
                grant_found = 1'b1;
                grant_idx   = cand_idx[k];
            end
        end
    end

    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_grant
            assign grant[gi] = grant_found && (grant_idx == IDW'(gi));
        end
    endgenerate

endmodule

// File: rtl/shiftadd_mul_scheduler.sv
// Shares one sequential shift-add multiplier engine between N_REQ requesters.
// Round-robin grant in IDLE, then LOAD (engine load), RUN (iterate until the
// engine's stop flag), DONE (hold tagged product until the consumer takes it).
// Optional feature macro: MUL_WDOG_EN adds a RUN watchdog that aborts a job
// whose engine never signals stop, returning product 0 with rsp_err set.
module shiftadd_mul_scheduler
    import shiftadd_mul_pkg::*;
#(
    parameter int W     = W_DEFAULT,
    parameter int N_REQ = N_REQ_DEFAULT,
    parameter int IDW   = idw_of(N_REQ)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_REQ-1:0]   req_valid,
    output logic [N_REQ-1:0]   req_ready,
    input  logic [N_REQ*W-1:0] req_b,
    input  logic [N_REQ*W-1:0] req_q,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [IDW-1:0]     rsp_id,
    output logic [2*W-1:0]     rsp_prod,
    output logic               rsp_err,
    output logic               mul_start,
    output logic [W-1:0]       mul_b,
    output logic [W-1:0]       mul_q,
    input  logic               mul_stop,
    input  logic [2*W-1:0]     mul_a,
    output logic               busy
);

    state_t           state_reg;
    logic [IDW-1:0]   ptr_reg;
    logic [IDW-1:0]   id_reg;
    logic [W-1:0]     mul_b_reg;
    logic [W-1:0]     mul_q_reg;
    logic             mul_start_reg;
    logic             rsp_valid_reg;
    logic [IDW-1:0]   rsp_id_reg;
    logic [2*W-1:0]   rsp_prod_reg;
    logic             busy_reg;

    logic [N_REQ-1:0] grant;
    logic [IDW-1:0]   grant_idx;
    logic             grant_found;
    logic [IDW-1:0]   ptr_next;
    logic [W-1:0]     sel_b;
    logic [W-1:0]     sel_q;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IDW   (IDW)
    ) u_arb (
        .req         (req_valid),
        .ptr         (ptr_reg),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_found (grant_found)
    );

    // Operands of the granted requester and the pointer position after it
    always_comb begin
        sel_b    = req_b[int'(grant_idx) * W +: W];
        sel_q    = req_q[int'(grant_idx) * W +: W];
        ptr_next = (grant_idx == IDW'(N_REQ - 1)) ? '0 : grant_idx + IDW'(1);
    end

    // Grants are only offered while idle; a grant bit implies its request is valid
    assign req_ready = (state_reg == IDLE) ? grant : '0;

`ifdef MUL_WDOG_EN
    localparam int WDOG_LIM = wdog_limit_of(W);
    localparam int WCW      = $clog2(WDOG_LIM + 1);
    logic [WCW-1:0] wdog_reg;
    logic           rsp_err_reg;
`endif

    // Scheduler FSM with all outputs registered
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= IDLE;
            ptr_reg       <= '0;
            id_reg        <= '0;
            mul_b_reg     <= '0;
            mul_q_reg     <= '0;
            mul_start_reg <= 1'b0;
            rsp_valid_reg <= 1'b0;
            rsp_id_reg    <= '0;
            rsp_prod_reg  <= '0;
            busy_reg      <= 1'b0;
`ifdef MUL_WDOG_EN
            wdog_reg      <= '0;
            rsp_err_reg   <= 1'b0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    if (grant_found) begin
                        mul_b_reg <= sel_b;
                        mul_q_reg <= sel_q;
                        id_reg    <= grant_idx;
                        ptr_reg   <= ptr_next;
                        busy_reg  <= 1'b1;
                        state_reg <= LOAD;
                    end
                end
                LOAD: begin
                    // The stop flag may still be set from the previous job here,
                    // so it is not looked at until the engine has reloaded.
                    mul_start_reg <= 1'b1;
                    state_reg     <= RUN;
`ifdef MUL_WDOG_EN
                    wdog_reg      <= '0;
`endif
                end
                RUN: begin
                    if (mul_stop) begin
                        rsp_prod_reg  <= mul_a;
                        rsp_id_reg    <= id_reg;
                        rsp_valid_reg <= 1'b1;
                        mul_start_reg <= 1'b0;
                        state_reg     <= DONE;
`ifdef MUL_WDOG_EN
                        rsp_err_reg   <= 1'b0;
                    end else if (wdog_reg == WCW'(WDOG_LIM - 1)) begin
                        rsp_prod_reg  <= '0;
                        rsp_id_reg    <= id_reg;
                        rsp_valid_reg <= 1'b1;
                        rsp_err_reg   <= 1'b1;
                        mul_start_reg <= 1'b0;
                        state_reg     <= DONE;
                    end else begin
                        wdog_reg      <= wdog_reg + WCW'(1);
`endif
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        rsp_valid_reg <= 1'b0;
                        busy_reg      <= 1'b0;
                        state_reg     <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign mul_start = mul_start_reg;
    assign mul_b     = mul_b_reg;
    assign mul_q     = mul_q_reg;
    assign rsp_valid = rsp_valid_reg;
    assign rsp_id    = rsp_id_reg;
    assign rsp_prod  = rsp_prod_reg;
    assign busy      = busy_reg;

`ifdef MUL_WDOG_EN
    assign rsp_err = rsp_err_reg;
`else
    assign rsp_err = 1'b0;
`endif

endmodule
